tag_free_list: RTL

TAG_FREE_LIST -- requirements
Module: tag_free_list

---
 rtl/tag_free_list_if.sv | 27 ++
 rtl/tag_free_list.sv | 76 +++++++
 2 files changed

// File: rtl/tag_free_list_if.sv
// Allocation/release/flush bundle between a tag free list and its consumer.
// The free list takes the slave side; the consumer takes the master side.
interface tag_free_list_if #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned TAG_W = $clog2(DEPTH)
);
    logic             i_alloc_ready;
    logic             o_alloc_valid;
    logic [TAG_W-1:0] o_alloc_tag;
    logic             i_rel_valid;
    logic [TAG_W-1:0] i_rel_tag;
    logic             i_flush;
    logic [TAG_W:0]   o_free_cnt;
    logic             o_empty;
    logic             o_full;
    logic             o_double_free;

    modport slave (
        input  i_alloc_ready, i_rel_valid, i_rel_tag, i_flush,
        output o_alloc_valid, o_alloc_tag, o_free_cnt, o_empty, o_full, o_double_free
    );

    modport master (
        output i_alloc_ready, i_rel_valid, i_rel_tag, i_flush,
        input  o_alloc_valid, o_alloc_tag, o_free_cnt, o_empty, o_full, o_double_free
    );
endinterface

// File: rtl/tag_free_list.sv
// Bitmap tag free list: offers the lowest free tag combinationally, takes one
// allocation and one release per cycle, and keeps a registered free count.
module tag_free_list #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned TAG_W = $clog2(DEPTH)
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    tag_free_list_if.slave bus
);
    localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

    logic [DEPTH-1:0] bitmap;
    logic [DEPTH-1:0] bitmap_next;
    logic [TAG_W:0]   free_cnt;
    logic [TAG_W:0]   cnt_next;
    logic             double_free;
    logic [TAG_W-1:0] low_tag;
    logic             any_free;
    logic             alloc_fire;
    logic             rel_in_range;
    logic             rel_hit_free;
    logic             rel_effective;

    // Descending scan so the lowest set index is the last one written.
    always_comb begin
        low_tag = '0;
        for (int unsigned i = DEPTH; i > 0; i--) begin
            if (bitmap[i-1]) low_tag = TAG_W'(i-1);
        end
    end

    generate
        if (DEPTH < (1 << TAG_W)) begin : g_range_check
            assign rel_in_range = ({1'b0, bus.i_rel_tag} < FULL_CNT);
        end else begin : g_range_full
            assign rel_in_range = 1'b1;
        end
    endgenerate

    assign any_free      = |bitmap;
    assign alloc_fire    = any_free & bus.i_alloc_ready;
    assign rel_hit_free  = bus.i_rel_valid & rel_in_range & bitmap[bus.i_rel_tag];
    assign rel_effective = bus.i_rel_valid & rel_in_range & ~bitmap[bus.i_rel_tag];

    // Allocation is applied after the release so a same-tag collision ends busy.
    always_comb begin
        bitmap_next = bitmap;
        if (bus.i_rel_valid && rel_in_range) bitmap_next[bus.i_rel_tag] = 1'b1;
        if (alloc_fire) bitmap_next[low_tag] = 1'b0;
        cnt_next = free_cnt - (TAG_W+1)'(alloc_fire) + (TAG_W+1)'(rel_effective);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bitmap      <= '1;
            free_cnt    <= FULL_CNT;
            double_free <= 1'b0;
        end else if (bus.i_flush) begin
            bitmap      <= '1;
            free_cnt    <= FULL_CNT;
            double_free <= 1'b0;
        end else begin
            bitmap      <= bitmap_next;
            free_cnt    <= cnt_next;
            double_free <= rel_hit_free;
        end
    end

    assign bus.o_alloc_valid = any_free;
    assign bus.o_alloc_tag   = low_tag;
    assign bus.o_free_cnt    = free_cnt;
    assign bus.o_empty       = ~any_free;
    assign bus.o_full        = (free_cnt == FULL_CNT);
    assign bus.o_double_free = double_free;
endmodule
